// File: rtl/sfr_ctrl_pkg.sv
// Shared definitions for the SFR write-port controller.
//   - One-hot select codes for the SFR input data mux.
//   - FSM state type (1-bit encoding).
package sfr_ctrl_pkg;

    // One-hot data select: bit0 = ex_mem_data_bot, bit1 = mem_wb_data_top,
    // bit2 = mem_wb_data_bot.
    localparam logic [2:0] SFR_SEL_NONE   = 3'b000;
    localparam logic [2:0] SFR_SEL_EX     = 3'b001;
    localparam logic [2:0] SFR_SEL_WB_TOP = 3'b010;
    localparam logic [2:0] SFR_SEL_WB_BOT = 3'b100;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WIDE_BOT = 1'b1
    } sfr_state_e;

endpackage

// File: rtl/sfr_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset, clears the count
//   inc_i    increment request for this cycle
//   count_o  current count; sticks at all-ones
module sfr_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sfr_write_ctrl.sv
// SFR write-port controller. Arbitrates between an 8-bit EX/MEM SFR write and a
// MEM/WB SFR write (8- or 16-bit) each cycle; a 16-bit MEM/WB write is split into
// a top beat at wb_sfr_addr and a bottom beat at wb_sfr_addr+1 on the next cycle.
// Outputs are combinational from state, latched bottom address and requests.
// Optional feature: define SFR_WR_CTRL_STATS_EN to add the stat_conflicts port,
// a 16-bit saturating count of cycles in which EX/MEM was held.
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   ex_sfr_req, ex_sfr_addr      EX/MEM 8-bit write request and address
//   wb_sfr_req, wb_sfr_wide,
//   wb_sfr_addr                  MEM/WB write request, 16-bit flag, address
//   sel_signals                  one-hot data mux select (0 when idle)
//   sfr_we, sfr_addr             SFR file write enable and address
//   hold_ex_mem, hold_mem_wb     pipeline register freezes
//   busy                         bottom beat of a wide write in progress
//   stat_conflicts               EX/MEM hold counter (stats build only)
module sfr_write_ctrl
    import sfr_ctrl_pkg::*;
#(
    parameter int unsigned SFR_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_sfr_req,
    input  logic [SFR_ADDR_W-1:0] ex_sfr_addr,
    input  logic                  wb_sfr_req,
    input  logic                  wb_sfr_wide,
    input  logic [SFR_ADDR_W-1:0] wb_sfr_addr,
    output logic [2:0]            sel_signals,
    output logic                  sfr_we,
    output logic [SFR_ADDR_W-1:0] sfr_addr,
    output logic                  hold_ex_mem,
    output logic                  hold_mem_wb,
    output logic                  busy
`ifdef SFR_WR_CTRL_STATS_EN
    ,
    output logic [15:0]           stat_conflicts
`endif
);

    sfr_state_e            state_d, state_q;
    logic [SFR_ADDR_W-1:0] bot_addr_d, bot_addr_q;

    always_comb begin
        state_d     = state_q;
        bot_addr_d  = bot_addr_q;
        sel_signals = SFR_SEL_NONE;
        sfr_addr    = '0;
        hold_ex_mem = 1'b0;
        hold_mem_wb = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // MEM/WB holds the older instruction, so it wins.
                if (wb_sfr_req) begin
                    sfr_addr = wb_sfr_addr;
                    if (wb_sfr_wide) begin
                        sel_signals = SFR_SEL_WB_TOP;
                        hold_ex_mem = 1'b1;
                        hold_mem_wb = 1'b1;
                        // Wraps modulo 2^SFR_ADDR_W.
                        bot_addr_d  = wb_sfr_addr + SFR_ADDR_W'(1);
                        state_d     = ST_WIDE_BOT;
                    end else begin
                        sel_signals = SFR_SEL_WB_BOT;
                        hold_ex_mem = ex_sfr_req;
                    end
                end else if (ex_sfr_req) begin
                    sel_signals = SFR_SEL_EX;
                    sfr_addr    = ex_sfr_addr;
                end
            end
            ST_WIDE_BOT: begin
                // Request inputs are don't-care here; MEM/WB is released so
                // the bottom byte is still on mem_wb_data_bot this cycle.
                sel_signals = SFR_SEL_WB_BOT;
                sfr_addr    = bot_addr_q;
                hold_ex_mem = ex_sfr_req;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset forces every output low, including mid-wide (aborts bottom beat).
        if (reset) begin
            sel_signals = SFR_SEL_NONE;
            sfr_addr    = '0;
            hold_ex_mem = 1'b0;
            hold_mem_wb = 1'b0;
        end
    end

    assign sfr_we = |sel_signals;
    assign busy   = (state_q == ST_WIDE_BOT) && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bot_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            bot_addr_q <= bot_addr_d;
        end
    end

`ifdef SFR_WR_CTRL_STATS_EN
    sfr_sat_counter #(
        .WIDTH(16)
    ) u_stats (
        .clk_i  (clock),
        .rst_i  (reset),
        .inc_i  (hold_ex_mem),
        .count_o(stat_conflicts)
    );
`endif

endmodule

// File: tb/tb_sfr_write_ctrl.sv
// Directed, table-driven bench for sfr_write_ctrl. Inputs change on the falling
// edge; outputs are checked 1 ns later, before the next rising edge.
module tb_sfr_write_ctrl;

    logic       clock;
    logic       reset;
    logic       ex_sfr_req;
    logic [4:0] ex_sfr_addr;
    logic       wb_sfr_req;
    logic       wb_sfr_wide;
    logic [4:0] wb_sfr_addr;
    logic [2:0] sel_signals;
    logic       sfr_we;
    logic [4:0] sfr_addr;
    logic       hold_ex_mem;
    logic       hold_mem_wb;
    logic       busy;
`ifdef SFR_WR_CTRL_STATS_EN
    logic [15:0] stat_conflicts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sfr_write_ctrl #(
        .SFR_ADDR_W(5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ex_sfr_req    (ex_sfr_req),
        .ex_sfr_addr   (ex_sfr_addr),
        .wb_sfr_req    (wb_sfr_req),
        .wb_sfr_wide   (wb_sfr_wide),
        .wb_sfr_addr   (wb_sfr_addr),
        .sel_signals   (sel_signals),
        .sfr_we        (sfr_we),
        .sfr_addr      (sfr_addr),
        .hold_ex_mem   (hold_ex_mem),
        .hold_mem_wb   (hold_mem_wb),
        .busy          (busy)
`ifdef SFR_WR_CTRL_STATS_EN
        ,
        .stat_conflicts(stat_conflicts)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       ex_req;
        logic [4:0] ex_addr;
        logic       wb_req;
        logic       wb_wide;
        logic [4:0] wb_addr;
        logic [2:0] sel;
        logic       we;
        logic [4:0] addr;
        logic       hex;
        logic       hwb;
        logic       bsy;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".sel"}, 32'(sel_signals), 32'd0);
        chk({tag, ".we"}, 32'(sfr_we), 32'd0);
        chk({tag, ".addr"}, 32'(sfr_addr), 32'd0);
        chk({tag, ".hex"}, 32'(hold_ex_mem), 32'd0);
        chk({tag, ".hwb"}, 32'(hold_mem_wb), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic drive(input logic ex, input logic [4:0] ea, input logic wb,
                         input logic wd, input logic [4:0] wa);
        ex_sfr_req  = ex;
        ex_sfr_addr = ea;
        wb_sfr_req  = wb;
        wb_sfr_wide = wd;
        wb_sfr_addr = wa;
    endtask

    initial begin
        //            ex ex_a   wb wd wb_a   sel     we addr   hex hwb busy
        vecs[0]  = '{0, 5'h00, 0, 0, 5'h00, 3'b000, 0, 5'h00, 0, 0, 0}; // idle
        vecs[1]  = '{1, 5'h03, 0, 0, 5'h00, 3'b001, 1, 5'h03, 0, 0, 0}; // EX alone
        vecs[2]  = '{1, 5'h04, 1, 0, 5'h04, 3'b100, 1, 5'h04, 1, 0, 0}; // WB wins
        vecs[3]  = '{1, 5'h04, 0, 0, 5'h04, 3'b001, 1, 5'h04, 0, 0, 0}; // held EX
        vecs[4]  = '{1, 5'h07, 1, 1, 5'h1F, 3'b010, 1, 5'h1F, 1, 1, 0}; // wide top
        vecs[5]  = '{1, 5'h07, 1, 1, 5'h1F, 3'b100, 1, 5'h00, 1, 0, 1}; // bot, wrap
        vecs[6]  = '{1, 5'h07, 0, 0, 5'h00, 3'b001, 1, 5'h07, 0, 0, 0}; // EX proceeds
        vecs[7]  = '{0, 5'h00, 1, 1, 5'h0A, 3'b010, 1, 5'h0A, 1, 1, 0}; // wide, no EX
        vecs[8]  = '{0, 5'h00, 1, 1, 5'h0A, 3'b100, 1, 5'h0B, 0, 0, 1}; // bot
        vecs[9]  = '{0, 5'h00, 1, 0, 5'h12, 3'b100, 1, 5'h12, 0, 0, 0}; // narrow WB
        vecs[10] = '{0, 5'h00, 0, 1, 5'h12, 3'b000, 0, 5'h00, 0, 0, 0}; // wide w/o req
        vecs[11] = '{0, 5'h00, 1, 1, 5'h05, 3'b010, 1, 5'h05, 1, 1, 0}; // wide top
        vecs[12] = '{0, 5'h00, 0, 0, 5'h1C, 3'b100, 1, 5'h06, 0, 0, 1}; // ignores inputs
        vecs[13] = '{0, 5'h00, 0, 0, 5'h00, 3'b000, 0, 5'h00, 0, 0, 0}; // idle again

        // Reset with every request high: all outputs forced low.
        reset = 1'b1;
        drive(1, 5'h1F, 1, 1, 5'h1F);
        @(negedge clock);
        @(negedge clock);
        #1;
        chk_all_zero("rst");
`ifdef SFR_WR_CTRL_STATS_EN
        chk("rst.stat", 32'(stat_conflicts), 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;
        drive(0, 5'h00, 0, 0, 5'h00);
        #1;
        chk_all_zero("post_rst");

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vecs[i].ex_req, vecs[i].ex_addr, vecs[i].wb_req, vecs[i].wb_wide,
                  vecs[i].wb_addr);
            #1;
            chk($sformatf("v%0d.sel", i), 32'(sel_signals), 32'(vecs[i].sel));
            chk($sformatf("v%0d.we", i), 32'(sfr_we), 32'(vecs[i].we));
            chk($sformatf("v%0d.addr", i), 32'(sfr_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d.hex", i), 32'(hold_ex_mem), 32'(vecs[i].hex));
            chk($sformatf("v%0d.hwb", i), 32'(hold_mem_wb), 32'(vecs[i].hwb));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
`ifdef SFR_WR_CTRL_STATS_EN
            // Holds occurred at vectors 2, 4, 5, 7 and 11.
            if (i == 3) chk("v3.stat", 32'(stat_conflicts), 32'd1);
            if (i == 13) chk("v13.stat", 32'(stat_conflicts), 32'd5);
`endif
        end

        // Reset during the bottom beat aborts the write.
        @(negedge clock);
        drive(0, 5'h00, 1, 1, 5'h09);
        #1;
        chk("mid.top.sel", 32'(sel_signals), 32'b010);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_all_zero("mid.rst");
        @(negedge clock);
        reset = 1'b0;
        drive(0, 5'h00, 0, 0, 5'h00);
        #1;
        chk_all_zero("mid.after");
`ifdef SFR_WR_CTRL_STATS_EN
        chk("mid.stat", 32'(stat_conflicts), 32'd0);

        // Saturation: preload near the top, keep EX/MEM held.
        @(negedge clock);
        force dut.u_stats.count_q = 16'hFFFE;
        #1;
        release dut.u_stats.count_q;
        drive(1, 5'h02, 1, 0, 5'h02);
        #1;
        chk("sat.hex", 32'(hold_ex_mem), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            #1;
            chk($sformatf("sat%0d.stat", k), 32'(stat_conflicts), 32'hFFFF);
        end
        drive(0, 5'h00, 0, 0, 5'h00);
`endif

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
